junction_controller: RTL and testbench

- Sequences a two-road junction: north-south (NS) and east-west (EW) light heads, each with red/amber/green using UK phasing (red, red+amber, green, amber, red).
- Adds timed phases, all-red clearance and a latched pedestrian request served during an all-red walk phase.
- Top-level controller for the junction; drives the lamp outputs directly.

---
 rtl/junction_controller.sv | 166 ++++++++++++++++
 tb/tb_junction_controller.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/junction_controller.sv
// Two-road junction controller with UK light phasing (red, red+amber, green,
// amber, red), all-red clearance and a latched pedestrian request that is
// served in an all-red walk phase. All outputs are registered and change on
// the same edge as the state.
// Optional feature: define NIGHT_FLASH_EN to add the night input and a FLASH
// state in which both amber heads blink together.
module junction_controller #(
  parameter int TW         = 4,
  parameter int T_REDAMBER = 2,
  parameter int T_GREEN    = 8,
  parameter int T_AMBER    = 3,
  parameter int T_ALLRED   = 2,
  parameter int T_WALK     = 6,
  parameter int T_FLASH    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic night,
`endif
  output logic ns_red,
  output logic ns_amber,
  output logic ns_green,
  output logic ew_red,
  output logic ew_amber,
  output logic ew_green,
  output logic walk,
  output logic ped_wait
);

  localparam logic [3:0] S_ALLRED_B = 4'd0;
  localparam logic [3:0] S_NS_RA    = 4'd1;
  localparam logic [3:0] S_NS_G     = 4'd2;
  localparam logic [3:0] S_NS_A     = 4'd3;
  localparam logic [3:0] S_ALLRED_A = 4'd4;
  localparam logic [3:0] S_EW_RA    = 4'd5;
  localparam logic [3:0] S_EW_G     = 4'd6;
  localparam logic [3:0] S_EW_A     = 4'd7;
  localparam logic [3:0] S_WALK     = 4'd8;
`ifdef NIGHT_FLASH_EN
  localparam logic [3:0] S_FLASH    = 4'd9;
`endif

  // Lamp vector order: {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk}
  localparam logic [6:0] L_BOTH_RED = 7'b100_100_0;

  logic [3:0]    state, nxt_state;
  logic [TW-1:0] timer, nxt_timer;
  logic          ped_pending, nxt_pending;
  logic          dir, nxt_dir;       // 1: walk was entered from ALLRED_A, resume with EW
  logic          enter_walk;
  logic [6:0]    nxt_lamps;
`ifdef NIGHT_FLASH_EN
  logic          flash_on, nxt_flash;
`endif

  // Phase length minus one, loaded into the timer when a state is entered.
  function automatic logic [TW-1:0] load_value(input logic [3:0] s);
    case (s)
      S_NS_RA, S_EW_RA: load_value = TW'(T_REDAMBER - 1);
      S_NS_G,  S_EW_G:  load_value = TW'(T_GREEN - 1);
      S_NS_A,  S_EW_A:  load_value = TW'(T_AMBER - 1);
      S_WALK:           load_value = TW'(T_WALK - 1);
`ifdef NIGHT_FLASH_EN
      S_FLASH:          load_value = TW'(T_FLASH - 1);
`endif
      default:          load_value = TW'(T_ALLRED - 1);
    endcase
  endfunction

  // Next-state, timer, direction and pedestrian-latch logic.
  always_comb begin
    nxt_state  = state;
    nxt_timer  = timer - TW'(1);
    nxt_dir    = dir;
    enter_walk = 1'b0;
`ifdef NIGHT_FLASH_EN
    nxt_flash  = flash_on;
    if (state == S_FLASH) begin
      if (!night) begin
        nxt_state = S_ALLRED_B;
        nxt_timer = load_value(S_ALLRED_B);
      end else if (timer == '0) begin
        nxt_timer = TW'(T_FLASH - 1);
        nxt_flash = ~flash_on;
      end
    end else
`endif
    if (timer == '0) begin
      case (state)
        S_ALLRED_B, S_ALLRED_A: begin
`ifdef NIGHT_FLASH_EN
          if (night) begin
            nxt_state = S_FLASH;
            nxt_flash = 1'b1;
          end else
`endif
          if (ped_pending) begin
            nxt_state  = S_WALK;
            nxt_dir    = (state == S_ALLRED_A);
            enter_walk = 1'b1;
          end else begin
            nxt_state = (state == S_ALLRED_B) ? S_NS_RA : S_EW_RA;
          end
        end
        S_NS_RA: nxt_state = S_NS_G;
        S_NS_G:  nxt_state = S_NS_A;
        S_NS_A:  nxt_state = S_ALLRED_A;
        S_EW_RA: nxt_state = S_EW_G;
        S_EW_G:  nxt_state = S_EW_A;
        S_EW_A:  nxt_state = S_ALLRED_B;
        S_WALK:  nxt_state = dir ? S_EW_RA : S_NS_RA;
        default: nxt_state = S_ALLRED_B;
      endcase
      nxt_timer = load_value(nxt_state);
    end
    // Requests are ignored during WALK; one arriving on the WALK entry edge is absorbed.
    if (state == S_WALK) nxt_pending = ped_pending;
    else                 nxt_pending = (ped_pending | ped_req) & ~enter_walk;
  end

  // Lamp decode of the state being entered, so the lamp registers track the state.
  always_comb begin
    nxt_lamps = L_BOTH_RED;
    case (nxt_state)
      S_NS_RA: nxt_lamps = 7'b110_100_0;
      S_NS_G:  nxt_lamps = 7'b001_100_0;
      S_NS_A:  nxt_lamps = 7'b010_100_0;
      S_EW_RA: nxt_lamps = 7'b100_110_0;
      S_EW_G:  nxt_lamps = 7'b100_001_0;
      S_EW_A:  nxt_lamps = 7'b100_010_0;
      S_WALK:  nxt_lamps = 7'b100_100_1;
`ifdef NIGHT_FLASH_EN
      S_FLASH: nxt_lamps = {1'b0, nxt_flash, 1'b0, 1'b0, nxt_flash, 1'b0, 1'b0};
`endif
      default: nxt_lamps = L_BOTH_RED;
    endcase
  end

  // State, timer and output registers with asynchronous reset to ALLRED_B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ALLRED_B;
      timer       <= TW'(T_ALLRED - 1);
      ped_pending <= 1'b0;
      dir         <= 1'b0;
`ifdef NIGHT_FLASH_EN
      flash_on    <= 1'b0;
`endif
      {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk} <= L_BOTH_RED;
      ped_wait    <= 1'b0;
    end else begin
      state       <= nxt_state;
      timer       <= nxt_timer;
      ped_pending <= nxt_pending;
      dir         <= nxt_dir;
`ifdef NIGHT_FLASH_EN
      flash_on    <= nxt_flash;
`endif
      {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk} <= nxt_lamps;
      ped_wait    <= nxt_pending;
    end
  end

endmodule

// File: tb/tb_junction_controller.sv
// Self-checking bench for junction_controller: a phase-table reference model
// is compared against the lamps every cycle, alongside the safety invariant,
// with literal expectations at known cycles and a randomized pedestrian run.
module tb_junction_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ped_req = 1'b0;
  logic ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_wait;
`ifdef NIGHT_FLASH_EN
  logic night = 1'b0;
`endif

  junction_controller dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req),
`ifdef NIGHT_FLASH_EN
    .night(night),
`endif
    .ns_red(ns_red), .ns_amber(ns_amber), .ns_green(ns_green),
    .ew_red(ew_red), .ew_amber(ew_amber), .ew_green(ew_green),
    .walk(walk), .ped_wait(ped_wait)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit started = 1'b0;

  // Reference model: position in the 8-phase ring plus a walk overlay.
  // Phases: 0 ALLRED_B, 1 NS_RA, 2 NS_G, 3 NS_A, 4 ALLRED_A, 5 EW_RA, 6 EW_G, 7 EW_A
  int       dur[8]    = '{2, 2, 8, 3, 2, 2, 8, 3};
  bit [2:0] ns_pat[8] = '{3'b100, 3'b110, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  bit [2:0] ew_pat[8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b110, 3'b001, 3'b010};
  int m_pos, m_cnt;
  bit m_walk, m_ret_ew, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_cnt = 0; m_walk = 0; m_ret_ew = 0; m_pend = 0;
      cyc = 0;
    end else begin
      bit was_walk, enter;
      was_walk = m_walk;
      enter = 0;
      cyc = cyc + 1;
      m_cnt = m_cnt + 1;
      if (m_walk) begin
        if (m_cnt == 6) begin
          m_walk = 0; m_cnt = 0;
          m_pos = m_ret_ew ? 5 : 1;
        end
      end else if (m_cnt == dur[m_pos]) begin
        m_cnt = 0;
        if ((m_pos == 0 || m_pos == 4) && m_pend) begin
          m_walk = 1; m_ret_ew = (m_pos == 4); enter = 1;
        end else begin
          m_pos = (m_pos + 1) % 8;
        end
      end
      if (!was_walk) m_pend = (m_pend | ped_req) & !enter;
    end
  end

  function automatic bit [7:0] model_vec();
    if (m_walk) return {3'b100, 3'b100, 1'b1, m_pend};
    return {ns_pat[m_pos], ew_pat[m_pos], 1'b0, m_pend};
  endfunction

  function automatic bit [7:0] dut_vec();
    return {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_wait};
  endfunction

  task automatic chk(input string name, input bit [7:0] got, input bit [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Every-cycle comparison of the DUT against the model plus the safety invariant.
  always @(negedge clk) begin
    if (started) begin
      bit safe;
      chk("model", dut_vec(), model_vec());
      safe = !((ns_amber | ns_green) && (ew_amber | ew_green));
      if (walk) safe = safe && ns_red && ew_red && !ns_amber && !ns_green && !ew_amber && !ew_green;
      chk("safety", {7'b0, safe}, 8'd1);
    end
  end

  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc != n) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        n_fail++;
        $display("FAIL timeout: waiting for cyc %0d, at %0d", n, cyc);
        return;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_vals", dut_vec(), 8'b100_100_00);
    rst_n = 1'b1;
    started = 1'b1;
    // Base cycle, no requests
    at_cyc(1);  chk("allred_b", dut_vec(), 8'b100_100_00);
    at_cyc(3);  chk("ns_ra",    dut_vec(), 8'b110_100_00);
    at_cyc(5);  chk("ns_g",     dut_vec(), 8'b001_100_00);
    at_cyc(13); chk("ns_a",     dut_vec(), 8'b010_100_00);
    at_cyc(16); chk("allred_a", dut_vec(), 8'b100_100_00);
    at_cyc(18); chk("ew_ra",    dut_vec(), 8'b100_110_00);
    at_cyc(20); chk("ew_g",     dut_vec(), 8'b100_001_00);
    at_cyc(28); chk("ew_a",     dut_vec(), 8'b100_010_00);
    at_cyc(30); chk("period30", dut_vec(), 8'b100_100_00);
    at_cyc(32); chk("ns_ra2",   dut_vec(), 8'b110_100_00);
    // One-cycle pulse during NS_G
    at_cyc(35); ped_req = 1'b1;
    at_cyc(36); ped_req = 1'b0; chk("ped_latched", dut_vec(), 8'b001_100_01);
    at_cyc(46); chk("allred_a_wait", dut_vec(), 8'b100_100_01);
    at_cyc(47); chk("walk_first",   dut_vec(), 8'b100_100_10);
    at_cyc(52); chk("walk_last",    dut_vec(), 8'b100_100_10);
    at_cyc(53); chk("after_walk_ew", dut_vec(), 8'b100_110_00);
    at_cyc(68); chk("period36",     dut_vec(), 8'b110_100_00);
    // Request held through WALK
    at_cyc(70); ped_req = 1'b1;
    at_cyc(84); chk("walk_held", dut_vec(), 8'b100_100_10);
    at_cyc(88); ped_req = 1'b0;
    at_cyc(89); chk("no_relatch", dut_vec(), 8'b100_110_00);
    // Request during EW_A, walk after ALLRED_B then NS
    at_cyc(100); ped_req = 1'b1;
    at_cyc(101); ped_req = 1'b0; chk("ewa_latched", dut_vec(), 8'b100_010_01);
    at_cyc(104); chk("walk_b", dut_vec(), 8'b100_100_10);
    at_cyc(110); chk("after_walk_ns", dut_vec(), 8'b110_100_00);
    // Asynchronous reset mid EW_G
    at_cyc(130); chk("ew_g_pre_rst", dut_vec(), 8'b100_001_00);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_vec(), 8'b100_100_00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    at_cyc(1); chk("restart_allred", dut_vec(), 8'b100_100_00);
    at_cyc(2); chk("restart_ns_ra",  dut_vec(), 8'b110_100_00);
    // Randomized pedestrian traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      ped_req = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
